tx_fc_credit_gate: RTL and testbench

- Transmit-side PCIe VC0 flow-control credit gate, the far-end counterpart of the per-class receiver buffers that advertise credit limits.
- Tracks Credit Limit (CL) and Credits Consumed (CC) for the six credit types: PH, PD, NPH, NPD, CplH, CplD.
- CL values arrive from InitFC/UpdateFC DLLPs. The block grants or stalls each outgoing TLP using the modular credit check.
- Sits between the TLP arbiter and the data-link layer transmit path.

---
 rtl/tx_fc_credit_gate.sv | 137 +++++++++++++
 tb/tb_tx_fc_credit_gate.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_fc_credit_gate.sv
// Transmit-side PCIe VC0 flow-control credit gate: tracks CL/CC for PH/PD/NPH/NPD/CplH/CplD
// and grants or stalls outgoing TLPs using the modular credit check.
module tx_fc_credit_gate #(
    parameter int HDR_W  = 8,
    parameter int DATA_W = 12
) (
    input  logic              tx_clk,
    input  logic              tx_rst_n,
    input  logic              fc_upd_valid,
    input  logic              fc_upd_init,
    input  logic [1:0]        fc_upd_class,
    input  logic [HDR_W-1:0]  fc_upd_hdr,
    input  logic [DATA_W-1:0] fc_upd_data,
    input  logic              tlp_valid,
    input  logic [1:0]        tlp_class,
    input  logic              tlp_has_data,
    input  logic [DATA_W-1:0] tlp_data_cred,
    output logic              tlp_ready,
    output logic              tlp_grant,
    output logic              fc_init_done,
    output logic [5:0]        credit_blocked
);

    localparam logic ST_INIT   = 1'b0;
    localparam logic ST_ACTIVE = 1'b1;

    localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

    logic              r_state;
    logic [2:0]        r_seen;
    logic [HDR_W-1:0]  r_cl_h [3];
    logic [HDR_W-1:0]  r_cc_h [3];
    logic [DATA_W-1:0] r_cl_d [3];
    logic [DATA_W-1:0] r_cc_d [3];
    logic [2:0]        r_inf_h;
    logic [2:0]        r_inf_d;
    logic              r_grant;
    logic              r_init_done;
    logic [5:0]        r_blocked;

    logic              w_active;
    logic              w_cls_ok;
    logic [1:0]        w_cls_idx;
    logic [HDR_W-1:0]  w_h_space;
    logic [DATA_W-1:0] w_d_space;
    logic              w_hdr_ok;
    logic              w_eff_data;
    logic              w_data_ok;
    logic              w_req;
    logic              w_hs;
    logic [2:0]        w_init_ld;
    logic [2:0]        w_upd_ld;
    logic [2:0]        w_seen_nxt;
    logic [5:0]        w_blocked;

    assign w_active  = (r_state == ST_ACTIVE);
    assign w_cls_ok  = (tlp_class != 2'b11);
    // Reserved class never reaches the array lookup; it is masked out of w_req.
    assign w_cls_idx = w_cls_ok ? tlp_class : 2'b00;

    assign w_h_space  = r_cl_h[w_cls_idx] - (r_cc_h[w_cls_idx] + 1'b1);
    assign w_hdr_ok   = r_inf_h[w_cls_idx] | (w_h_space <= HDR_HALF);
    assign w_eff_data = tlp_has_data & (tlp_data_cred != '0);
    assign w_d_space  = r_cl_d[w_cls_idx] - (r_cc_d[w_cls_idx] + tlp_data_cred);
    assign w_data_ok  = ~w_eff_data | r_inf_d[w_cls_idx] | (w_d_space <= DATA_HALF);

    assign w_req     = w_active & tlp_valid & w_cls_ok;
    assign tlp_ready = w_req & w_hdr_ok & w_data_ok;
    assign w_hs      = tlp_valid & tlp_ready;

    always_comb begin
        w_init_ld = '0;
        w_upd_ld  = '0;
        for (int c = 0; c < 3; c++) begin
            w_init_ld[c] = ~w_active & fc_upd_valid & fc_upd_init & (fc_upd_class == 2'(c));
            w_upd_ld[c]  = w_active & fc_upd_valid & ~fc_upd_init & (fc_upd_class == 2'(c));
        end
    end

    assign w_seen_nxt = r_seen | w_init_ld;

    always_comb begin
        w_blocked = '0;
        if (w_req) begin
            w_blocked[{w_cls_idx, 1'b0}] = ~w_hdr_ok;
            w_blocked[{w_cls_idx, 1'b1}] = ~w_data_ok;
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            r_state     <= ST_INIT;
            r_seen      <= '0;
            r_inf_h     <= '0;
            r_inf_d     <= '0;
            r_grant     <= 1'b0;
            r_init_done <= 1'b0;
            r_blocked   <= '0;
            for (int c = 0; c < 3; c++) begin
                r_cl_h[c] <= '0;
                r_cc_h[c] <= '0;
                r_cl_d[c] <= '0;
                r_cc_d[c] <= '0;
            end
        end else begin
            r_grant   <= w_hs;
            r_blocked <= w_blocked;
            r_seen    <= w_seen_nxt;
            if (!w_active && (w_seen_nxt == 3'b111)) begin
                r_state     <= ST_ACTIVE;
                r_init_done <= 1'b1;
            end
            for (int c = 0; c < 3; c++) begin
                // A zero field in InitFC means infinite; later UpdateFCs leave it alone.
                if (w_init_ld[c]) begin
                    r_cl_h[c]  <= fc_upd_hdr;
                    r_inf_h[c] <= (fc_upd_hdr == '0);
                    r_cl_d[c]  <= fc_upd_data;
                    r_inf_d[c] <= (fc_upd_data == '0);
                end else if (w_upd_ld[c]) begin
                    if (!r_inf_h[c]) r_cl_h[c] <= fc_upd_hdr;
                    if (!r_inf_d[c]) r_cl_d[c] <= fc_upd_data;
                end
                if (w_hs && (w_cls_idx == 2'(c))) begin
                    if (!r_inf_h[c]) r_cc_h[c] <= r_cc_h[c] + 1'b1;
                    if (w_eff_data && !r_inf_d[c]) r_cc_d[c] <= r_cc_d[c] + tlp_data_cred;
                end
            end
        end
    end

    assign tlp_grant      = r_grant;
    assign fc_init_done   = r_init_done;
    assign credit_blocked = r_blocked;

endmodule

// File: tb/tb_tx_fc_credit_gate.sv
// Self-checking bench for tx_fc_credit_gate: directed scenarios plus randomized traffic,
// all compared against an arithmetic credit model.
module tb_tx_fc_credit_gate;

    localparam int HDR_W  = 8;
    localparam int DATA_W = 12;
    localparam int HM = 255, HH = 128, DM = 4095, DH = 2048;

    logic              tx_clk = 1'b0;
    logic              tx_rst_n = 1'b0;
    logic              fc_upd_valid = 1'b0;
    logic              fc_upd_init = 1'b0;
    logic [1:0]        fc_upd_class = 2'b00;
    logic [HDR_W-1:0]  fc_upd_hdr = '0;
    logic [DATA_W-1:0] fc_upd_data = '0;
    logic              tlp_valid = 1'b0;
    logic [1:0]        tlp_class = 2'b00;
    logic              tlp_has_data = 1'b0;
    logic [DATA_W-1:0] tlp_data_cred = '0;
    logic              tlp_ready;
    logic              tlp_grant;
    logic              fc_init_done;
    logic [5:0]        credit_blocked;

    always #5 tx_clk = ~tx_clk;

    tx_fc_credit_gate #(.HDR_W(HDR_W), .DATA_W(DATA_W)) dut (
        .tx_clk        (tx_clk),
        .tx_rst_n      (tx_rst_n),
        .fc_upd_valid  (fc_upd_valid),
        .fc_upd_init   (fc_upd_init),
        .fc_upd_class  (fc_upd_class),
        .fc_upd_hdr    (fc_upd_hdr),
        .fc_upd_data   (fc_upd_data),
        .tlp_valid     (tlp_valid),
        .tlp_class     (tlp_class),
        .tlp_has_data  (tlp_has_data),
        .tlp_data_cred (tlp_data_cred),
        .tlp_ready     (tlp_ready),
        .tlp_grant     (tlp_grant),
        .fc_init_done  (fc_init_done),
        .credit_blocked(credit_blocked)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: credit ledger per class, plain integers.
    bit       m_active;
    bit [2:0] m_seen;
    int       m_cl_h[3], m_cc_h[3], m_cl_d[3], m_cc_d[3];
    bit       m_inf_h[3], m_inf_d[3];
    bit       m_grant, m_done;
    logic [5:0] m_blk;

    bit         e_ready;
    logic [5:0] e_blk;
    bit         o_ready;

    function automatic void model_reset();
        m_active = 0; m_seen = 0; m_grant = 0; m_done = 0; m_blk = '0;
        for (int c = 0; c < 3; c++) begin
            m_cl_h[c] = 0; m_cc_h[c] = 0; m_cl_d[c] = 0; m_cc_d[c] = 0;
            m_inf_h[c] = 0; m_inf_d[c] = 0;
        end
    endfunction

    function automatic bit needs_data();
        return tlp_has_data && (tlp_data_cred != 0);
    endfunction

    function automatic void model_gate(output bit rdy, output logic [5:0] blk);
        int c;
        bit hok, dok;
        rdy = 0;
        blk = '0;
        if (!m_active || tlp_valid !== 1'b1 || tlp_class == 2'b11) return;
        c   = int'(tlp_class);
        hok = m_inf_h[c] || (((m_cl_h[c] - m_cc_h[c] - 1) & HM) <= HH);
        dok = !needs_data() || m_inf_d[c] ||
              (((m_cl_d[c] - m_cc_d[c] - int'(tlp_data_cred)) & DM) <= DH);
        blk[2*c]   = !hok;
        blk[2*c+1] = !dok;
        rdy = hok && dok;
    endfunction

    function automatic void model_edge(bit hs, logic [5:0] blk);
        int c = int'(tlp_class);
        int u = int'(fc_upd_class);
        if (hs) begin
            if (!m_inf_h[c]) m_cc_h[c] = (m_cc_h[c] + 1) & HM;
            if (needs_data() && !m_inf_d[c]) m_cc_d[c] = (m_cc_d[c] + int'(tlp_data_cred)) & DM;
        end
        if (fc_upd_valid && u != 3) begin
            if (!m_active && fc_upd_init) begin
                m_cl_h[u] = int'(fc_upd_hdr);  m_inf_h[u] = (fc_upd_hdr == 0);
                m_cl_d[u] = int'(fc_upd_data); m_inf_d[u] = (fc_upd_data == 0);
                m_seen[u] = 1'b1;
            end else if (m_active && !fc_upd_init) begin
                if (!m_inf_h[u]) m_cl_h[u] = int'(fc_upd_hdr);
                if (!m_inf_d[u]) m_cl_d[u] = int'(fc_upd_data);
            end
        end
        if (!m_active && m_seen == 3'b111) begin
            m_active = 1;
            m_done   = 1;
        end
        m_grant = hs;
        m_blk   = blk;
    endfunction

    // One clock: sample ready at negedge, advance model at posedge, return at posedge+1.
    task automatic tick();
        @(negedge tx_clk);
        model_gate(e_ready, e_blk);
        o_ready = tlp_ready;
        @(posedge tx_clk);
        model_edge(e_ready && tlp_valid, e_blk);
        #1;
    endtask

    task automatic set_upd(input bit init, input int cls, input int h, input int d);
        fc_upd_valid = 1'b1;
        fc_upd_init  = init;
        fc_upd_class = 2'(cls);
        fc_upd_hdr   = HDR_W'(h);
        fc_upd_data  = DATA_W'(d);
    endtask

    task automatic clr_upd();
        fc_upd_valid = 1'b0;
        fc_upd_init  = 1'b0;
    endtask

    task automatic set_tlp(input bit v, input int cls, input bit hd, input int cred);
        tlp_valid     = v;
        tlp_class     = 2'(cls);
        tlp_has_data  = hd;
        tlp_data_cred = DATA_W'(cred);
    endtask

    task automatic test_reset();
        model_reset();
        tx_rst_n = 1'b0;
        #12;
        n_vec++;
        if ({tlp_ready, tlp_grant, fc_init_done, credit_blocked} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b gnt=%b done=%b blk=%b want all 0",
                     tlp_ready, tlp_grant, fc_init_done, credit_blocked);
        end
        @(negedge tx_clk);
        #2 tx_rst_n = 1'b1;
        @(posedge tx_clk);
        #1;
    endtask

    task automatic test_init();
        bit [2:0] rdy_seen = 0;
        set_tlp(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: set_upd(1, 0, 2, 16);
                1: set_upd(1, 1, 1, 1);
                default: set_upd(1, 2, 0, 0);
            endcase
            tick();
            rdy_seen[i] = o_ready;
            n_vec++;
            if (fc_init_done !== (i == 2)) begin
                n_err++;
                $display("FAIL init_done_step%0d: got %b want %b", i, fc_init_done, (i == 2));
            end
        end
        clr_upd();
        set_tlp(0, 0, 0, 0);
        n_vec++;
        if (rdy_seen !== 3'b000) begin
            n_err++;
            $display("FAIL init_ready_held: got %b want 000", rdy_seen);
        end
    endtask

    task automatic test_hdr_exhaust();
        int grants = 0;
        set_tlp(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            grants += int'(o_ready);
            n_vec++;
            if ({o_ready, tlp_grant, credit_blocked} !== {e_ready, m_grant, m_blk}) begin
                n_err++;
                $display("FAIL hdr_exh_%0d: got rdy=%b gnt=%b blk=%b want rdy=%b gnt=%b blk=%b",
                         i, o_ready, tlp_grant, credit_blocked, e_ready, m_grant, m_blk);
            end
        end
        n_vec++;
        if (grants != 2 || credit_blocked !== 6'b000001) begin
            n_err++;
            $display("FAIL hdr_exh_stall: got grants=%0d blk=%b want 2 and 000001",
                     grants, credit_blocked);
        end
        set_upd(0, 0, 3, 16);
        tick();
        clr_upd();
        tick();
        n_vec++;
        if (o_ready !== 1'b1 || tlp_grant !== 1'b1 || credit_blocked !== 6'b0) begin
            n_err++;
            $display("FAIL hdr_exh_release: got rdy=%b gnt=%b blk=%b want 1 1 000000",
                     o_ready, tlp_grant, credit_blocked);
        end
        set_tlp(0, 0, 0, 0);
    endtask

    task automatic test_data_limit();
        set_upd(0, 0, 10, 16);
        tick();
        clr_upd();
        set_tlp(1, 0, 1, 17);
        tick();
        n_vec++;
        if (o_ready !== 1'b0 || credit_blocked !== 6'b000010) begin
            n_err++;
            $display("FAIL data_over: got rdy=%b blk=%b want 0 000010", o_ready, credit_blocked);
        end
        set_tlp(1, 0, 1, 16);
        tick();
        n_vec++;
        if (o_ready !== 1'b1 || tlp_grant !== 1'b1) begin
            n_err++;
            $display("FAIL data_exact: got rdy=%b gnt=%b want 1 1", o_ready, tlp_grant);
        end
        set_tlp(1, 0, 1, 1);
        tick();
        n_vec++;
        if (o_ready !== 1'b0 || credit_blocked !== 6'b000010) begin
            n_err++;
            $display("FAIL data_consumed: got rdy=%b blk=%b want 0 000010", o_ready, credit_blocked);
        end
        set_tlp(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_infinite();
        int grants = 0;
        int nrdy = 0;
        logic [5:0] blk_or = '0;
        set_tlp(1, 2, 1, 100);
        for (int i = 0; i < 300; i++) begin
            tick();
            nrdy   += int'(o_ready);
            grants += int'(tlp_grant);
            blk_or |= credit_blocked;
            n_vec++;
            if ({o_ready, tlp_grant} !== {e_ready, m_grant}) begin
                n_err++;
                $display("FAIL inf_%0d: got rdy=%b gnt=%b want %b %b",
                         i, o_ready, tlp_grant, e_ready, m_grant);
            end
        end
        set_tlp(0, 0, 0, 0);
        n_vec++;
        if (nrdy != 300 || grants != 300 || blk_or !== 6'b0) begin
            n_err++;
            $display("FAIL inf_total: got rdy=%0d gnt=%0d blk=%b want 300 300 000000",
                     nrdy, grants, blk_or);
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        int grants = 0;
        while (m_cc_h[0] != 254 && guard < 10) begin
            guard++;
            set_upd(0, 0, (m_cc_h[0] + 100 > 254) ? 254 : m_cc_h[0] + 100, m_cl_d[0]);
            tick();
            clr_upd();
            set_tlp(1, 0, 0, 0);
            for (int i = 0; i < 120; i++) begin
                tick();
                n_vec++;
                if (o_ready !== e_ready) begin
                    n_err++;
                    $display("FAIL wrap_fill: got rdy=%b want %b", o_ready, e_ready);
                end
                if (!o_ready) break;
            end
            set_tlp(0, 0, 0, 0);
        end
        set_upd(0, 0, 4, m_cl_d[0]);
        tick();
        clr_upd();
        set_tlp(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!o_ready) break;
            grants++;
        end
        n_vec++;
        if (grants != 6 || credit_blocked !== 6'b000001) begin
            n_err++;
            $display("FAIL wrap_count: got grants=%0d blk=%b want 6 000001", grants, credit_blocked);
        end
        set_tlp(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_random();
        int held = 0;
        int c;
        for (int i = 0; i < 600; i++) begin
            if (tlp_valid && !o_ready && held < 6) begin
                held++;
            end else begin
                held = 0;
                set_tlp(($urandom % 4) != 0, int'($urandom % 4), 1'($urandom),
                        int'($urandom_range(0, 40)));
            end
            if (($urandom % 4) == 0) begin
                c = int'($urandom % 4);
                set_upd(($urandom % 8) == 0, c,
                        (c < 3 ? m_cc_h[c] : 0) + int'($urandom_range(0, 30)),
                        (c < 3 ? m_cc_d[c] : 0) + int'($urandom_range(0, 300)));
            end else begin
                clr_upd();
            end
            tick();
            n_vec++;
            if ({o_ready, tlp_grant, fc_init_done, credit_blocked} !==
                {e_ready, m_grant, m_done, m_blk}) begin
                n_err++;
                $display("FAIL rand_%0d: got rdy=%b gnt=%b done=%b blk=%b want %b %b %b %b", i,
                         o_ready, tlp_grant, fc_init_done, credit_blocked,
                         e_ready, m_grant, m_done, m_blk);
            end
        end
        clr_upd();
        set_tlp(0, 0, 0, 0);
        tick();
    endtask

    task automatic test_async_reset();
        int grants = 0;
        set_upd(0, 1, m_cc_h[1], m_cl_d[1]);
        tick();
        clr_upd();
        set_tlp(1, 1, 0, 0);
        tick();
        tick();
        n_vec++;
        if (o_ready !== 1'b0 || credit_blocked !== 6'b000100) begin
            n_err++;
            $display("FAIL rst_prestall: got rdy=%b blk=%b want 0 000100", o_ready, credit_blocked);
        end
        #2 tx_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({tlp_ready, tlp_grant, fc_init_done, credit_blocked} !== 9'b0) begin
            n_err++;
            $display("FAIL rst_async: got rdy=%b gnt=%b done=%b blk=%b want all 0",
                     tlp_ready, tlp_grant, fc_init_done, credit_blocked);
        end
        model_reset();
        @(negedge tx_clk);
        #2 tx_rst_n = 1'b1;
        tick();
        n_vec++;
        if (o_ready !== 1'b0 || fc_init_done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_init_state: got rdy=%b done=%b want 0 0", o_ready, fc_init_done);
        end
        set_tlp(0, 0, 0, 0);
        set_upd(1, 0, 1, 0);
        tick();
        set_upd(1, 1, 1, 1);
        tick();
        set_upd(1, 2, 0, 0);
        tick();
        clr_upd();
        set_tlp(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            grants += int'(o_ready);
            n_vec++;
            if ({o_ready, tlp_grant, credit_blocked} !== {e_ready, m_grant, m_blk}) begin
                n_err++;
                $display("FAIL rst_post_%0d: got rdy=%b gnt=%b blk=%b want %b %b %b", i,
                         o_ready, tlp_grant, credit_blocked, e_ready, m_grant, m_blk);
            end
        end
        n_vec++;
        if (grants != 1) begin
            n_err++;
            $display("FAIL rst_cleared: got grants=%0d want 1", grants);
        end
        set_tlp(0, 0, 0, 0);
        tick();
    endtask

    initial begin
        test_reset();
        test_init();
        test_hdr_exhaust();
        test_data_limit();
        test_infinite();
        test_wrap();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
